register_file: RTL and testbench
================================

Name: register_file

Overview:
Parametrised multi-register successor to the single 16-bit `register` block, intended as the CPU datapath register file. It holds DEPTH registers of WIDTH bits. It has one clocked write port with regWrite enable, two combinational read ports, and a synchronous bulk clear. Register 0 can be hardwired to zero for the ISA's zero register.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 3, width of all address ports.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears every register to 0 while low.
- regWrite  input  1  write enable for the write port.
- clear  input  1  synchronous clear of all registers.
- writeAddr  input  ADDR_W  write port address.
- writeData  input  WIDTH  write port data.
- readAddrA  input  ADDR_W  read port A address.
- readAddrB  input  ADDR_W  read port B address.
- readDataA  output  WIDTH  read port A data (combinational from storage).
- readDataB  output  WIDTH  read port B data (combinational from storage).
- writeErr  output  1  registered flag: last accepted write was out of range or targeted hardwired reg 0.

Behaviour:
- Reset:
  - reset low asserts asynchronously, independent of CLK: all registers = 0, writeErr = 0.
  - readDataA/B read 0 within the same delta for any in-range address.
  - Release of reset is sampled on the next CLK rising edge; no write occurs on an edge while reset is low.
- Write:
  - On rising CLK with reset high, regWrite = 1, clear = 0, writeAddr < DEPTH, and not (ZERO_REG = 1 and writeAddr = 0): reg[writeAddr] <= writeData.
  - New value is visible on a read port addressing it after the edge (latency 1 cycle, matching `register`).
- Rejected write:
  - Applies when writeAddr >= DEPTH, or ZERO_REG = 1 and writeAddr = 0, with regWrite = 1.
  - Storage is unchanged and writeErr <= 1 on that edge.
  - Any edge with regWrite = 1 and a valid target sets writeErr <= 0.
  - Edges with regWrite = 0 hold writeErr.
- Clear:
  - clear = 1 on a rising edge sets all registers to 0 and writeErr to 0.
  - clear has priority over a simultaneous regWrite; the write is dropped.
- Read:
  - readDataX = reg[readAddrX] when readAddrX < DEPTH, else 0.
  - Reads of address 0 return 0 when ZERO_REG = 1, regardless of storage.
  - Both ports may address the same register, or the write address, at once.
- Same-cycle read of write address: without the optional feature, readDataX shows the old value until the edge.
- Data is treated as an unsigned bit vector; no sign extension or arithmetic. The full 2**WIDTH range must round-trip unchanged.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when regWrite = 1, clear = 0, reset high, the write is valid, and readAddrX = writeAddr, readDataX = writeData combinationally in the same cycle (write-through forwarding for the pipeline).
  - Bypass is suppressed for rejected writes, so zero reg and out-of-range still read 0.
- Not defined: no forwarding; reads always reflect stored contents only.

Test Plan:
1. reset low mid-cycle after writing reg3 = 16'h1234 -> readDataA (addr 3) = 0 immediately, before any CLK edge; writeErr = 0.
2. Write reg1 = -32768 (16'h8000) and reg7 = 16'h7FFF, read A = 1 and B = 7 next cycle -> 16'h8000 and 16'h7FFF. Then sweep all 65536 values through reg5 -> each value read back one cycle after its write.
3. ZERO_REG = 1, write reg0 = 16'hBEEF -> readDataA (addr 0) = 0 and writeErr = 1. Then a valid write of reg2 = 5 -> writeErr = 0.
4. DEPTH = 6, ADDR_W = 3, write addr 6 = 16'hAAAA -> no register changes, writeErr = 1; read addr 7 -> 0.
5. clear = 1 with regWrite = 1 to reg4 = 16'h00FF, after registers are loaded with nonzero values -> all reads return 0 next cycle, reg4 = 0.
6. Write reg2 = 16'h0042 while readAddrA = 2 in the same cycle:
   - with REGFILE_WRITE_BYPASS_EN -> readDataA = 16'h0042 before the edge;
   - without it -> old value before the edge, 16'h0042 after.

Source files
------------

// File: rtl/register_file.sv
// rtl/register_file.sv - DEPTH x WIDTH register file, one write port, two combinational read ports
// Optional write-through forwarding to the read ports: define REGFILE_WRITE_BYPASS_EN.
module register_file #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              regWrite,
   input  logic              clear,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [WIDTH-1:0]  writeData,
   input  logic [ADDR_W-1:0] readAddrA,
   input  logic [ADDR_W-1:0] readAddrB,
   output logic [WIDTH-1:0]  readDataA,
   output logic [WIDTH-1:0]  readDataB,
   output logic              writeErr
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic             r_write_err;
   logic             w_wr_target_ok;
   logic             w_wr_valid;
   logic             w_fwd_en;

   // A target is legal when it exists and is not the hardwired zero register
   assign w_wr_target_ok = ({1'b0, writeAddr} < LP_DEPTH) &&
                           !(ZERO_REG && (writeAddr == '0));
   assign w_wr_valid     = regWrite && w_wr_target_ok;
   assign w_fwd_en       = w_wr_valid && !clear && reset;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_write_err <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_write_err <= 1'b0;
      end else if (regWrite) begin
         if (w_wr_target_ok) r_regs[writeAddr] <= writeData;
         r_write_err <= !w_wr_target_ok;
      end
   end

   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [WIDTH-1:0] data;
      data = '0;
      if (({1'b0, addr} < LP_DEPTH) && !(ZERO_REG && (addr == '0))) begin
         data = r_regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
         if (w_fwd_en && (addr == writeAddr)) data = writeData;
`endif
      end
      return data;
   endfunction

   always_comb begin
      readDataA = '0;
      readDataB = '0;
      readDataA = read_port(readAddrA);
      readDataB = read_port(readAddrB);
   end

`ifndef REGFILE_WRITE_BYPASS_EN
   logic w_fwd_unused;
   assign w_fwd_unused = w_fwd_en;
`endif

   assign writeErr = r_write_err;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

   logic        CLK = 1'b0;
   logic        reset;
   logic        regWrite;
   logic        clear;
   logic [2:0]  writeAddr;
   logic [15:0] writeData;
   logic [2:0]  readAddrA;
   logic [2:0]  readAddrB;
   logic [15:0] rdA, rdB, rdA6, rdB6;
   logic        err, err6;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int sweep_errs = 0;
   logic [15:0] first_bad = '0;

   always #5 CLK = ~CLK;

   register_file #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut (
      .CLK(CLK), .reset(reset), .regWrite(regWrite), .clear(clear),
      .writeAddr(writeAddr), .writeData(writeData),
      .readAddrA(readAddrA), .readAddrB(readAddrB),
      .readDataA(rdA), .readDataB(rdB), .writeErr(err)
   );

   register_file #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1'b1)) dut6 (
      .CLK(CLK), .reset(reset), .regWrite(regWrite), .clear(clear),
      .writeAddr(writeAddr), .writeData(writeData),
      .readAddrA(readAddrA), .readAddrB(readAddrB),
      .readDataA(rdA6), .readDataB(rdB6), .writeErr(err6)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      regWrite  = 1'b1;
      writeAddr = a;
      writeData = d;
      tick();
      regWrite  = 1'b0;
   endtask

   initial begin
      reset = 1'b0; regWrite = 1'b0; clear = 1'b0;
      writeAddr = '0; writeData = '0; readAddrA = '0; readAddrB = '0;
      tick();
      readAddrA = 3'd3;
      #1;
      check("reset_rdA", rdA, 16'h0000);
      check("reset_err", {15'd0, err}, 16'h0000);
      reset = 1'b1;
      tick();

      // async reset mid-cycle
      wr(3'd3, 16'h1234);
      readAddrA = 3'd3;
      #1;
      check("wr3_read", rdA, 16'h1234);
      #2 reset = 1'b0;
      #1;
      check("async_rst_rdA", rdA, 16'h0000);
      check("async_rst_err", {15'd0, err}, 16'h0000);
      tick();
      reset = 1'b1;
      tick();

      // boundary values and full sweep
      wr(3'd1, 16'h8000);
      wr(3'd7, 16'h7FFF);
      readAddrA = 3'd1; readAddrB = 3'd7;
      #1;
      check("rd_8000", rdA, 16'h8000);
      check("rd_7fff", rdB, 16'h7FFF);
      check("err_valid", {15'd0, err}, 16'h0000);
      regWrite = 1'b1; writeAddr = 3'd5; readAddrA = 3'd5;
      for (int v = 0; v < 65536; v++) begin
         writeData = 16'(v);
         tick();
         if (rdA !== 16'(v)) begin
            if (sweep_errs == 0) first_bad = 16'(v);
            sweep_errs++;
         end
      end
      regWrite = 1'b0;
      check("sweep_errs", 16'(sweep_errs), 16'h0000);
      check("sweep_first_bad", first_bad, 16'h0000);

      // zero register
      wr(3'd0, 16'hBEEF);
      readAddrA = 3'd0;
      #1;
      check("zero_rd", rdA, 16'h0000);
      check("zero_err", {15'd0, err}, 16'h0001);
      tick();
      check("err_hold", {15'd0, err}, 16'h0001);
      wr(3'd2, 16'h0005);
      readAddrA = 3'd2;
      #1;
      check("err_cleared", {15'd0, err}, 16'h0000);
      check("rd_reg2", rdA, 16'h0005);

      // out of range on DEPTH=6 instance
      wr(3'd6, 16'hAAAA);
      readAddrA = 3'd7; readAddrB = 3'd5;
      #1;
      check("oor_err6", {15'd0, err6}, 16'h0001);
      check("oor_rd7", rdA6, 16'h0000);
      check("oor_reg5_kept", rdB6, 16'hFFFF);
      check("d8_reg6_ok", {15'd0, err}, 16'h0000);
      readAddrA = 3'd6;
      #1;
      check("oor_rd6", rdA6, 16'h0000);
      check("d8_rd6", rdA, 16'hAAAA);

      // clear beats write
      wr(3'd4, 16'h1111);
      wr(3'd0, 16'h0001);
      check("pre_clear_err", {15'd0, err}, 16'h0001);
      clear = 1'b1;
      wr(3'd4, 16'h00FF);
      clear = 1'b0;
      readAddrA = 3'd4; readAddrB = 3'd1;
      #1;
      check("clr_reg4", rdA, 16'h0000);
      check("clr_reg1", rdB, 16'h0000);
      check("clr_err", {15'd0, err}, 16'h0000);
      readAddrA = 3'd5;
      #1;
      check("clr_d6_reg5", rdA6, 16'h0000);

      // same-cycle read of write address
      wr(3'd2, 16'h0007);
      regWrite = 1'b1; writeAddr = 3'd2; writeData = 16'h0042; readAddrA = 3'd2;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      check("same_cyc_before", rdA, 16'h0042);
`else
      check("same_cyc_before", rdA, 16'h0007);
`endif
      tick();
      regWrite = 1'b0;
      check("same_cyc_after", rdA, 16'h0042);
      regWrite = 1'b1; writeAddr = 3'd0; writeData = 16'hFFFF; readAddrA = 3'd0;
      #1;
      check("no_fwd_zero", rdA, 16'h0000);
      regWrite = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
